// File: rtl/mod_reduce_pipe_pkg.sv
// Shared word/wide types and Barrett constant helper for the modular-reduction datapaths.
// Elaboration-time only; no logic lives here.
package mod_reduce_pipe_pkg;

  localparam int W_BITS_L = 16;
  localparam int Q_MOD_L  = 97;
  localparam int MU_MAX_W = 128;

  typedef logic [W_BITS_L-1:0]          word_t;
  typedef logic signed [2*W_BITS_L-1:0] wide_t;

  // floor(2^k / q); wide enough for any k below MU_MAX_W, so NTT blocks can reuse it.
  function automatic logic [MU_MAX_W-1:0] barrett_mu(input int unsigned q, input int unsigned k);
    logic [MU_MAX_W-1:0] num;
    num    = '0;
    num[k] = 1'b1;
    return num / MU_MAX_W'(q);
  endfunction

endpackage

// File: rtl/mod_reduce_pipe_if.sv
// Valid/ready bundle for the reduction pipe: input vector + tag, output vector + tag.
// slave = pipe side, master = producer/consumer side.
interface mod_reduce_pipe_if
  import mod_reduce_pipe_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = W_BITS_L,
  parameter int WW    = 2*W_BITS_L,
  parameter int TAG_W = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*WW-1:0]   in_data;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*W-1:0]    out_data;
  logic [TAG_W-1:0]      out_tag;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/mod_reduce_pipe_barrett_lane.sv
// One lane of Barrett reduction split into four combinational stage functions.
// Purely combinational; the parent owns all stage registers and flow control.
module mod_reduce_pipe_barrett_lane
  import mod_reduce_pipe_pkg::*;
#(
  parameter int          W  = W_BITS_L,
  parameter int          WW = 2*W_BITS_L,
  parameter int unsigned Q  = Q_MOD_L
) (
  input  logic [WW-1:0]  x,
  output logic           s1_sign_nx,
  output logic [WW-1:0]  s1_mag_nx,
  input  logic [WW-1:0]  s1_mag,
  output logic [W+1:0]   s2_mag_nx,
  output logic [W+1:0]   s2_qhat_nx,
  input  logic [W+1:0]   s2_mag,
  input  logic [W+1:0]   s2_qhat,
  output logic [W+1:0]   s3_rem_nx,
  input  logic           s3_sign,
  input  logic [W+1:0]   s3_rem,
  output logic [W-1:0]   out_nx
);

  localparam int                    K       = WW;
  localparam int                    RW      = W + 2;
  localparam logic [MU_MAX_W-1:0]   MU_FULL = barrett_mu(Q, K);
  localparam logic [K:0]            MU      = MU_FULL[K:0];
  localparam logic [RW-1:0]         Q_R     = RW'(Q);

  // Unsigned negate: the most negative input maps to 2^(WW-1), which still fits WW bits.
  function automatic logic [WW-1:0] stage1_mag(input logic [WW-1:0] v);
    return v[WW-1] ? -v : v;
  endfunction

  // Only the low RW bits of qhat matter: the remainder is computed modulo 2^RW.
  function automatic logic [RW-1:0] stage2_qhat(input logic [WW-1:0] m);
    logic [WW+K:0] prod;
    prod = {{(K+1){1'b0}}, m} * {{WW{1'b0}}, MU};
    return RW'(prod >> K);
  endfunction

  function automatic logic [RW-1:0] stage3_rem(input logic [RW-1:0] m, input logic [RW-1:0] qhat);
    return m - qhat * Q_R;
  endfunction

  function automatic logic [W-1:0] stage4_fix(input logic sign, input logic [RW-1:0] r);
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic [RW-1:0] res;
    r1  = (r  >= Q_R) ? r  - Q_R : r;
    r2  = (r1 >= Q_R) ? r1 - Q_R : r1;
    res = (sign && (r2 != '0)) ? Q_R - r2 : r2;
    return W'(res);
  endfunction

  assign s1_sign_nx = x[WW-1];
  assign s1_mag_nx  = stage1_mag(x);
  assign s2_mag_nx  = RW'(s1_mag);
  assign s2_qhat_nx = stage2_qhat(s1_mag);
  assign s3_rem_nx  = stage3_rem(s2_mag, s2_qhat);
  assign out_nx     = stage4_fix(s3_sign, s3_rem);

endmodule

// File: rtl/mod_reduce_pipe.sv
// LANES-wide signed mod-Q reduction, 4-stage Barrett pipe, one vector per cycle.
// Whole pipe advances only when the output slot is empty or being popped; stalls freeze every stage.
module mod_reduce_pipe
  import mod_reduce_pipe_pkg::*;
#(
  parameter int          LANES = 4,
  parameter int          W     = W_BITS_L,
  parameter int          WW    = 2*W_BITS_L,
  parameter int unsigned Q     = Q_MOD_L,
  parameter int          TAG_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  mod_reduce_pipe_if.slave    io,
  output logic                busy
);

  localparam int RW = W + 2;

  logic adv;

  logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d, out_valid_q, out_valid_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, s3_tag_q, s3_tag_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [LANES-1:0] s1_sign_q, s1_sign_d, s2_sign_q, s2_sign_d, s3_sign_q, s3_sign_d;
  logic [LANES-1:0][WW-1:0] s1_mag_q, s1_mag_d;
  logic [LANES-1:0][RW-1:0] s2_mag_q, s2_mag_d, s2_qhat_q, s2_qhat_d;
  logic [LANES-1:0][RW-1:0] s3_rem_q, s3_rem_d;
  logic [LANES-1:0][W-1:0]  out_data_q, out_data_d;

  logic [LANES-1:0]         s1_sign_nx;
  logic [LANES-1:0][WW-1:0] s1_mag_nx;
  logic [LANES-1:0][RW-1:0] s2_mag_nx, s2_qhat_nx, s3_rem_nx;
  logic [LANES-1:0][W-1:0]  out_nx;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mod_reduce_pipe_barrett_lane #(
      .W  (W),
      .WW (WW),
      .Q  (Q)
    ) u_barrett_lane (
      .x          (io.in_data[i*WW +: WW]),
      .s1_sign_nx (s1_sign_nx[i]),
      .s1_mag_nx  (s1_mag_nx[i]),
      .s1_mag     (s1_mag_q[i]),
      .s2_mag_nx  (s2_mag_nx[i]),
      .s2_qhat_nx (s2_qhat_nx[i]),
      .s2_mag     (s2_mag_q[i]),
      .s2_qhat    (s2_qhat_q[i]),
      .s3_rem_nx  (s3_rem_nx[i]),
      .s3_sign    (s3_sign_q[i]),
      .s3_rem     (s3_rem_q[i]),
      .out_nx     (out_nx[i])
    );
  end

  assign adv          = !out_valid_q || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_tag   = out_tag_q;
  assign busy         = s1_vld_q || s2_vld_q || s3_vld_q || out_valid_q;

  // Valid bits always shift on adv so bubbles keep their slot; payload only loads behind
  // a valid entry, which keeps out_data stable once valid drops.
  always_comb begin
    s1_vld_d    = s1_vld_q;
    s2_vld_d    = s2_vld_q;
    s3_vld_d    = s3_vld_q;
    out_valid_d = out_valid_q;
    s1_tag_d    = s1_tag_q;
    s2_tag_d    = s2_tag_q;
    s3_tag_d    = s3_tag_q;
    out_tag_d   = out_tag_q;
    s1_sign_d   = s1_sign_q;
    s2_sign_d   = s2_sign_q;
    s3_sign_d   = s3_sign_q;
    s1_mag_d    = s1_mag_q;
    s2_mag_d    = s2_mag_q;
    s2_qhat_d   = s2_qhat_q;
    s3_rem_d    = s3_rem_q;
    out_data_d  = out_data_q;
    if (adv) begin
      s1_vld_d    = io.in_valid;
      s2_vld_d    = s1_vld_q;
      s3_vld_d    = s2_vld_q;
      out_valid_d = s3_vld_q;
      if (io.in_valid) begin
        s1_tag_d  = io.in_tag;
        s1_sign_d = s1_sign_nx;
        s1_mag_d  = s1_mag_nx;
      end
      if (s1_vld_q) begin
        s2_tag_d  = s1_tag_q;
        s2_sign_d = s1_sign_q;
        s2_mag_d  = s2_mag_nx;
        s2_qhat_d = s2_qhat_nx;
      end
      if (s2_vld_q) begin
        s3_tag_d  = s2_tag_q;
        s3_sign_d = s2_sign_q;
        s3_rem_d  = s3_rem_nx;
      end
      if (s3_vld_q) begin
        out_tag_d  = s3_tag_q;
        out_data_d = out_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      s1_tag_q    <= '0;
      s2_tag_q    <= '0;
      s3_tag_q    <= '0;
      out_tag_q   <= '0;
      s1_sign_q   <= '0;
      s2_sign_q   <= '0;
      s3_sign_q   <= '0;
      s1_mag_q    <= '0;
      s2_mag_q    <= '0;
      s2_qhat_q   <= '0;
      s3_rem_q    <= '0;
      out_data_q  <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      s3_vld_q    <= s3_vld_d;
      out_valid_q <= out_valid_d;
      s1_tag_q    <= s1_tag_d;
      s2_tag_q    <= s2_tag_d;
      s3_tag_q    <= s3_tag_d;
      out_tag_q   <= out_tag_d;
      s1_sign_q   <= s1_sign_d;
      s2_sign_q   <= s2_sign_d;
      s3_sign_q   <= s3_sign_d;
      s1_mag_q    <= s1_mag_d;
      s2_mag_q    <= s2_mag_d;
      s2_qhat_q   <= s2_qhat_d;
      s3_rem_q    <= s3_rem_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mod_reduce_pipe.sv
// Directed and scoreboarded checks of mod_reduce_pipe at W=16, WW=32, Q=97, LANES=4.
module tb_mod_reduce_pipe;
  import mod_reduce_pipe_pkg::*;

  localparam int          LANES = 4;
  localparam int          W     = 16;
  localparam int          WW    = 32;
  localparam int unsigned Q     = 97;
  localparam int          TAG_W = 8;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  logic [71:0]  sb[$];
  logic [127:0] bp[4];
  int           first_pop, last_pop;

  mod_reduce_pipe_if #(.LANES(LANES), .W(W), .WW(WW), .TAG_W(TAG_W)) io ();

  mod_reduce_pipe #(
    .LANES (LANES),
    .W     (W),
    .WW    (WW),
    .Q     (Q),
    .TAG_W (TAG_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] gold(input logic [127:0] d);
    logic [63:0] r;
    longint      x;
    longint      m;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      x = $signed(d[i*32 +: 32]);
      m = ((x % 97) + 97) % 97;
      r[i*16 +: 16] = m[15:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] pack4(input wide_t l0, input wide_t l1, input wide_t l2, input wide_t l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [127:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_traffic(input string tag, input int n, input int pv, input int pr,
                             input int budget, output int first, output int last);
    int           pushed;
    int           popped;
    int           cyc;
    logic [127:0] vec;
    logic [71:0]  exp;
    pushed = 0; popped = 0; cyc = 0; first = -1; last = -1;
    sb.delete();
    while (((pushed < n) || (sb.size() != 0)) && (cyc < budget)) begin
      vec          = rand_vec();
      io.in_valid  = (pushed < n) && ($urandom_range(99) < pv);
      io.in_data   = vec;
      io.in_tag    = 8'(pushed);
      io.out_ready = ($urandom_range(99) < pr);
      #1;
      if (io.out_valid && io.out_ready) begin
        if (sb.size() == 0) begin
          chk({tag, "_spurious"}, io.out_valid, 0);
        end else begin
          exp = sb.pop_front();
          chk(tag, {io.out_tag, io.out_data}, exp);
          popped++;
          if (first < 0) first = cyc;
          last = cyc;
        end
      end
      if (io.in_valid && io.in_ready) begin
        sb.push_back({io.in_tag, gold(vec)});
        pushed++;
      end
      step();
      cyc++;
    end
    io.in_valid = 1'b0;
    chk({tag, "_count"}, popped, n);
  endtask

  initial begin
    // Reset with in_valid high and out_ready low
    reset        = 1'b1;
    io.in_valid  = 1'b1;
    io.in_data   = rand_vec();
    io.in_tag    = 8'hFF;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", io.out_data, 0);
    chk("rst_out_tag", io.out_tag, 0);
    reset       = 1'b0;
    io.in_valid = 1'b0;
    #1 chk("rst_in_ready", io.in_ready, 1);
    step();

    // Basic: {0, 97, 96, 98} -> {0, 0, 96, 1}, tag 5A, 4-cycle latency
    io.in_data   = pack4(0, 97, 96, 98);
    io.in_tag    = 8'h5A;
    io.in_valid  = 1'b1;
    io.out_ready = 1'b1;
    #1 chk("basic_in_ready", io.in_ready, 1);
    step();
    io.in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("basic_latency", io.out_valid, (i == 4));
      if (i < 4) step();
    end
    chk("basic_data", io.out_data, 64'h0001_0060_0000_0000);
    chk("basic_tag", io.out_tag, 8'h5A);
    step();
    #1 chk("basic_drained", io.out_valid, 0);
    chk("basic_idle", busy, 0);

    // Signed edges: {-1, -97, -2^31, 2^31-1} -> {96, 0, 31, 65}
    io.in_data  = pack4(-1, -97, 32'sh8000_0000, 32'sh7FFF_FFFF);
    io.in_tag   = 8'hA5;
    io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    repeat (3) step();
    #1 chk("signed_valid", io.out_valid, 1);
    chk("signed_data", io.out_data, 64'h0041_001F_0000_0060);
    chk("signed_tag", io.out_tag, 8'hA5);
    step();

    // Streaming: 100 back-to-back vectors, outputs on consecutive cycles
    run_traffic("stream", 100, 100, 100, 400, first_pop, last_pop);
    chk("stream_gapless", last_pop - first_pop, 99);

    // Backpressure: fill all 4 stages, stall 10 cycles, then drain
    io.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bp[k]       = rand_vec();
      io.in_data  = bp[k];
      io.in_tag   = 8'(k);
      io.in_valid = 1'b1;
      #1 chk("bp_fill_ready", io.in_ready, 1);
      step();
    end
    #1 chk("bp_full_valid", io.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      io.in_valid = i[0];
      io.in_data  = rand_vec();
      io.in_tag   = 8'hEE;
      #1;
      chk("bp_in_ready", io.in_ready, 0);
      chk("bp_hold", {io.out_tag, io.out_data}, {8'h00, gold(bp[0])});
      chk("bp_busy", busy, 1);
      step();
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_drain_valid", io.out_valid, 1);
      chk("bp_drain", {io.out_tag, io.out_data}, {8'(k), gold(bp[k])});
      step();
    end
    #1 chk("bp_no_dup", io.out_valid, 0);
    chk("bp_idle", busy, 0);

    // Random stall: 30% out_ready low, 50% in_valid, 1000 vectors
    run_traffic("stall", 1000, 50, 70, 8000, first_pop, last_pop);

    // Reset with 3 vectors in flight
    io.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      io.in_data  = rand_vec();
      io.in_tag   = 8'(k + 8'h40);
      io.in_valid = 1'b1;
      step();
    end
    #1 chk("rstm_busy_before", busy, 1);
    reset = 1'b1;
    step();
    #1;
    chk("rstm_out_valid", io.out_valid, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_out_data", io.out_data, 0);
    reset       = 1'b0;
    io.in_valid = 1'b0;
    #1 chk("rstm_in_ready", io.in_ready, 1);
    io.in_data  = pack4(1000, -1000, 12345, -12345);
    io.in_tag   = 8'h3C;
    io.in_valid = 1'b1;
    step();
    io.in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("rstm_latency", io.out_valid, (i == 4));
      if (i < 4) step();
    end
    chk("rstm_data", io.out_data, 64'h0047_001A_0043_001E);
    chk("rstm_tag", io.out_tag, 8'h3C);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
